// File: rtl/y1_pkg.sv
// Shared pattern definition for the 16-input detector: FSM state encoding,
// the match word and its don't-care width, plus a small mask helper.
package y1_pkg;

  // Generator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLIP  = 2'd2,
    ST_FIN   = 2'd3
  } y1_state_e;

  // Match word with every don't-care bit cleared.
  localparam logic [15:0] Y1_BASE    = 16'h4628;
  // Number of low-order don't-care bits in the match word.
  localparam int          Y1_DC_BITS = 3;
  // Burst counter width; terminal counts are compared explicitly, so it never wraps.
  localparam int          Y1_CNT_W   = 5;

  // Mask covering the low-order don't-care bits.
  function automatic logic [15:0] y1_dc_mask(input int dc_bits);
    return 16'((32'd1 << dc_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/y1_gen.sv
// Stimulus generator for the 16-input pattern detector.
// A burst first sweeps every don't-care combination on top of BASE (all of
// these must match), then optionally flips each care bit once (none of these
// may match). Each word carries the detector output it should produce.
//
// Handshake: a word is offered while valid_o=1; it is transferred only in a
// cycle where valid_o=1 and ready_i=1. While valid_o=1 and ready_i=0,
// data_o/expect_o hold and valid_o stays high. ready_i is ignored when
// valid_o=0. With ready_i held high one word moves every cycle.
module y1_gen
  import y1_pkg::*;
#(
  parameter logic [15:0] BASE    = Y1_BASE,
  parameter int          DC_BITS = Y1_DC_BITS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [15:0] data_o,
  output logic        expect_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SWEEP = ST_SWEEP;
  localparam logic [1:0] S_FLIP  = ST_FLIP;
  localparam logic [1:0] S_FIN   = ST_FIN;

  localparam logic [15:0]         DC_MASK    = y1_dc_mask(DC_BITS);
  // Last sweep count and first flip index, both from the don't-care width.
  localparam logic [Y1_CNT_W-1:0] SWEEP_LAST = Y1_CNT_W'((32'd1 << DC_BITS) - 32'd1);
  localparam logic [Y1_CNT_W-1:0] FLIP_FIRST = Y1_CNT_W'(DC_BITS);
  localparam logic [Y1_CNT_W-1:0] FLIP_LAST  = Y1_CNT_W'(15);

  logic [1:0]          state_q, state_d;
  logic [Y1_CNT_W-1:0] cnt_q,   cnt_d;
  logic                mode_q,  mode_d;

  logic                valid_w;
  logic                xfer_w;

  assign xfer_w = valid_w & ready_i;

  // Word forming: purely a function of state, counter and parameters, so the
  // offered word cannot change while the counter is held during a stall.
  always_comb begin
    valid_w  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    expect_o = 1'b0;
    data_o   = 16'h0000;
    case (state_q)
      S_SWEEP: begin
        valid_w  = 1'b1;
        busy_o   = 1'b1;
        expect_o = 1'b1;
        data_o   = BASE | (16'(cnt_q) & DC_MASK);
      end
      S_FLIP: begin
        valid_w  = 1'b1;
        busy_o   = 1'b1;
        expect_o = 1'b0;
        data_o   = BASE ^ (16'h0001 << cnt_q[3:0]);
      end
      S_FIN: begin
        done_o = 1'b1;
      end
      default: begin
        valid_w = 1'b0;
      end
    endcase
  end

  assign valid_o = valid_w;
  assign state_o = state_q;

  // Next-state logic: the counter only moves on a transfer, and the phase
  // ends on an explicit terminal-count compare rather than on wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          mode_d  = mode_i;
        end
      end
      S_SWEEP: begin
        if (xfer_w) begin
          if (cnt_q == SWEEP_LAST) begin
            if (mode_q) begin
              state_d = S_FLIP;
              cnt_d   = FLIP_FIRST;
            end else begin
              state_d = S_FIN;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLIP: begin
        if (xfer_w) begin
          if (cnt_q == FLIP_LAST) begin
            state_d = S_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        // One-cycle done pulse; start is deliberately not looked at here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        mode_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset that abandons any burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_y1_gen.sv
// Directed bench for y1_gen: burst sequences, stalls, ignored starts,
// asynchronous reset mid-burst and mode changes while busy.
module tb_y1_gen;
  import y1_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        ready;
  logic        valid;
  logic [15:0] data;
  logic        exp_bit;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int cyc;

  logic [16:0] exp_q[$];
  logic [15:0] flip_tbl [13];
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  y1_gen dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .mode_i   (mode),
    .ready_i  (ready),
    .valid_o  (valid),
    .data_o   (data),
    .expect_o (exp_bit),
    .busy_o   (busy),
    .done_o   (done),
    .state_o  (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference detector: care bits of the word must equal the match word.
  function automatic logic det(input logic [15:0] w);
    return (w & 16'hFFF8) == 16'h4628;
  endfunction

  // Scoreboard: every transfer pops the expected word; stalls must hold.
  always @(negedge clk) begin
    if (prev_stall)
      check("stall_hold", {14'b0, valid, exp_bit, data}, {14'b0, 1'b1, prev_word});
    prev_stall = valid && !ready;
    prev_word  = {exp_bit, data};
    if (valid && ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_xfer", 32'(exp_q.size()), 32'(1));
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("xfer_word", {15'b0, exp_bit, data}, {15'b0, e});
        check("detector", 32'(det(data)), 32'(exp_bit));
      end
    end
    if (done) done_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic m);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 16'h4628 + 16'(i)});
    if (m) for (int i = 0; i < 13; i++) exp_q.push_back({1'b0, flip_tbl[i]});
    xfer_cnt = 0;
    done_cnt = 0;
  endtask

  // Start is high during cycle 0; returns 1 ns into cycle 1.
  task automatic pulse_start(input logic m);
    step();
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  // Runs from cycle c0 until done is seen; pat=1 drives ready 1-0-0.
  task automatic wait_done(input int c0, input int pat, input int budget, output int c_done);
    logic seen;
    seen   = 1'b0;
    c_done = -1;
    for (int c = c0; c < c0 + budget; c++) begin
      ready = (pat == 0) ? 1'b1 : ((c % 3) == 1);
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        c_done = c;
        break;
      end
      step();
    end
    check("done_seen", 32'(seen), 32'(1));
    ready = 1'b1;
  endtask

  task automatic post(input string tag, input int n);
    step();
    @(negedge clk);
    check({tag, "_idle"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_valid"}, 32'(valid), 32'(0));
    check({tag, "_xfers"}, 32'(xfer_cnt), 32'(n));
    check({tag, "_left"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_dones"}, 32'(done_cnt), 32'(1));
  endtask

  // Directed sequence
  initial begin
    flip_tbl = '{16'h4620, 16'h4638, 16'h4608, 16'h4668, 16'h46A8, 16'h4728, 16'h4428,
                 16'h4228, 16'h4E28, 16'h5628, 16'h6628, 16'h0628, 16'hC628};
    rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_expect", 32'(exp_bit), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_state", 32'(state), 32'(ST_IDLE));
    step();
    rst = 1'b0;

    // ready without a burst does nothing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_valid", 32'(valid), 32'(0));
      check("idle_ready_state", 32'(state), 32'(ST_IDLE));
    end

    // Scenario 1: sweep only, ready tied high, cycle-exact
    load_exp(1'b0);
    pulse_start(1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("s1_valid", 32'(valid), 32'(1));
      check("s1_data", 32'(data), 32'(16'h4627 + 16'(i)));
      check("s1_expect", 32'(exp_bit), 32'(1));
      check("s1_busy", 32'(busy), 32'(1));
      step();
    end
    @(negedge clk);
    check("s1_done", 32'(done), 32'(1));
    check("s1_busy_fin", 32'(busy), 32'(0));
    check("s1_valid_fin", 32'(valid), 32'(0));
    check("s1_state_fin", 32'(state), 32'(ST_FIN));
    step();
    @(negedge clk);
    check("s1_done_gone", 32'(done), 32'(0));
    check("s1_xfers", 32'(xfer_cnt), 32'(8));
    check("s1_dones", 32'(done_cnt), 32'(1));

    // Scenario 2: sweep then flips, no bubbles
    load_exp(1'b1);
    pulse_start(1'b1);
    wait_done(1, 0, 60, cyc);
    check("s2_done_cycle", 32'(cyc), 32'(22));
    post("s2", 21);

    // Scenario 3: ready 1-0-0 pattern
    load_exp(1'b1);
    pulse_start(1'b1);
    wait_done(1, 1, 200, cyc);
    post("s3", 21);

    // Scenario 4: start at cycle 4 and in the FIN cycle are ignored
    load_exp(1'b1);
    pulse_start(1'b1);
    repeat (3) step();
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    repeat (17) step();
    start = 1'b1;
    @(negedge clk);
    check("s4_fin_done", 32'(done), 32'(1));
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_no_restart", 32'(valid), 32'(0));
      step();
    end
    check("s4_xfers", 32'(xfer_cnt), 32'(21));
    check("s4_dones", 32'(done_cnt), 32'(1));
    check("s4_left", 32'(exp_q.size()), 32'(0));

    // Scenario 5: asynchronous reset after the 5th transfer
    load_exp(1'b1);
    pulse_start(1'b1);
    repeat (5) step();
    check("s5_xfers_before", 32'(xfer_cnt), 32'(5));
    #2;
    rst = 1'b1;
    #1;
    check("s5_rst_valid", 32'(valid), 32'(0));
    check("s5_rst_data", 32'(data), 32'(0));
    check("s5_rst_expect", 32'(exp_bit), 32'(0));
    check("s5_rst_busy", 32'(busy), 32'(0));
    check("s5_rst_state", 32'(state), 32'(ST_IDLE));
    exp_q.delete();
    step();
    rst = 1'b0;
    repeat (2) step();
    check("s5_no_done", 32'(done_cnt), 32'(0));
    load_exp(1'b0);
    pulse_start(1'b0);
    @(negedge clk);
    check("s5_first_word", 32'(data), 32'(16'h4628));
    wait_done(1, 0, 60, cyc);
    post("s5", 8);

    // Scenario 6: mode flips to 1 mid-sweep, burst still sweep-only
    load_exp(1'b0);
    pulse_start(1'b0);
    repeat (2) step();
    mode = 1'b1;
    wait_done(3, 0, 60, cyc);
    check("s6_done_cycle", 32'(cyc), 32'(9));
    post("s6", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/y1_gen.md
Y1_GEN -- requirements
Module: y1_gen

Interface
REQ-001 Parameter BASE, default 16'h4628; the matching word with all don't-care bits zero.
REQ-002 Parameter DC_BITS, default 3; the number of low-order don't-care bits (1..4); BASE[DC_BITS-1:0] SHALL be zero.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-006 mode  input  1  sampled with start; 0 = sweep only, 1 = sweep then near-miss flips.
REQ-007 ready  input  1  downstream (detector bench) accepts the word.
REQ-008 valid  output  1  data/expect hold a word.
REQ-009 data  output  16  stimulus word; bit i drives detector input pi<i>.
REQ-010 expect  output  1  required detector output po0 for the current word.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-013 The block SHALL generate stimulus for the 16-input pattern detector: sweep words match, flip words do not.
REQ-014 The FSM SHALL have the states IDLE, SWEEP, FLIP and FIN.
REQ-015 IDLE: valid=0 and busy=0; start=1 SHALL latch mode, clear the counter and go to SWEEP at the next edge, so valid is high one cycle after start.
REQ-016 SWEEP: data = BASE | cnt and expect=1, for cnt = 0 .. 2^DC_BITS-1.
REQ-017 FLIP: data = BASE ^ (1 << i) and expect=0, for i = DC_BITS .. 15 in ascending order.
REQ-018 Default sequence: sweep 0x4628..0x462F (8 words), then flip 0x4620, 0x4638, 0x4608, 0x4668, 0x46A8, 0x4728, 0x4428, 0x4228, 0x4E28, 0x5628, 0x6628, 0x0628, 0xC628 (13 words).
REQ-019 A transfer SHALL occur only in a cycle where valid=1 and ready=1; the counter advances on transfer only.
REQ-020 While valid=1 and ready=0, data and expect SHALL hold stable and valid SHALL stay high.
REQ-021 Back-to-back transfers SHALL be supported: with ready held high, one word is transferred per cycle with no bubbles, including across the SWEEP->FLIP boundary.
REQ-022 A transfer of the last sweep word SHALL go to FLIP if mode=1 and to FIN if mode=0; a transfer of the i=15 flip word SHALL go to FIN.
REQ-023 FIN SHALL last exactly one cycle with done=1, valid=0 and busy=0, then return to IDLE.
REQ-024 start SHALL be ignored outside IDLE, including in FIN.
REQ-025 Changes on mode while busy SHALL have no effect.
REQ-026 The counter SHALL be 5 bits wide; counter wrap SHALL NOT occur because terminal counts are compared explicitly.
REQ-027 ready=1 while valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, latched mode 0, valid=0, expect=0, data=16'h0000, busy=0 and done=0.
REQ-029 Reset mid-burst SHALL abandon the burst with no done pulse; the first start after reset release SHALL begin again at cnt=0.

Structure
REQ-030 A shared package y1_pkg SHALL hold the FSM state enum, Y1_BASE=16'h4628 and Y1_DC_BITS=3, so that the detector bench and the generator share one pattern definition.
REQ-031 The block SHALL be a single module with no sub-modules; the word-forming logic SHALL be a combinational function of state, counter and parameters.

Verification
REQ-032 Scenario 1: reset, then start=1 with mode=0 and ready tied 1 -> valid high at cycles 1..8 with data 0x4628..0x462F and expect=1, done pulse at cycle 9, busy low at cycle 9.
REQ-033 Scenario 2: start with mode=1 and ready=1 -> 21 consecutive words matching REQ-018, done at cycle 22; each word fed to the detector yields po0 == expect.
REQ-034 Scenario 3: mode=1 with ready toggling in a 1-0-0 pattern -> no word dropped or duplicated; data stable throughout every stall; 21 transfers total.
REQ-035 Scenario 4: a second start pulse at cycle 4 of a burst, and a start in the FIN cycle -> both ignored; exactly one done pulse.
REQ-036 Scenario 5: rst asserted asynchronously mid-clock after the 5th transfer -> outputs reach reset values before the next edge; a new start produces 0x4628 first.
REQ-037 Scenario 6: mode changed from 0 to 1 mid-sweep -> burst still ends after 8 words.
